// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: chain of STAGES valid/ready register slots with bubble collapsing and flush.
// Define PIPE_STALL_CNT_EN to build the saturating output-stall counter on stall_cnt.
module elastic_pipe_reg #(
   parameter int               WIDTH     = 32,
   parameter int               STAGES    = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [2:0]       occupancy,
   output logic [31:0]      stall_cnt
);
   if (STAGES < 1 || STAGES > 7) begin : g_bad_stages
      $error("elastic_pipe_reg: STAGES must be within 1..7");
   end
   logic [WIDTH-1:0]  r_data [STAGES];
   logic [STAGES-1:0] r_valid;
   logic [2:0]        r_occ;
   logic [STAGES-1:0] w_adv;
   logic              w_in_x;
   logic              w_out_x;
   // A slot may advance when the output drains or any slot at or after it is empty.
   for (genvar i = 0; i < STAGES; i++) begin : g_adv
      assign w_adv[i] = out_ready || !(&r_valid[STAGES-1:i]);
   end
   assign in_ready  = w_adv[0] && !flush;
   assign out_valid = r_valid[STAGES-1] && !flush;
   assign out_data  = r_data[STAGES-1];
   assign occupancy = r_occ;
   assign w_in_x    = in_valid && in_ready;
   assign w_out_x   = out_valid && out_ready;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_occ   <= '0;
         for (int i = 0; i < STAGES; i++) r_data[i] <= RESET_VAL;
      end else if (flush) begin
         r_valid <= '0;
         r_occ   <= '0;
      end else begin
         if (w_adv[0]) r_valid[0] <= in_valid;
         if (w_in_x) r_data[0] <= in_data;
         for (int i = 1; i < STAGES; i++) begin
            if (w_adv[i]) r_valid[i] <= r_valid[i-1];
            if (w_adv[i] && r_valid[i-1]) r_data[i] <= r_data[i-1];
         end
         r_occ <= r_occ + {2'b0, w_in_x} - {2'b0, w_out_x};
      end
   end
`ifdef PIPE_STALL_CNT_EN
   logic [31:0] r_stall_cnt;
   always_ff @(posedge clk) begin
      if (rst) r_stall_cnt <= '0;
      else if (out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 32'd1;
   end
   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'h0;
`endif
endmodule

// File: doc/elastic_pipe_reg.md
Name: elastic_pipe_reg

Overview:
- Parametrised successor to the fixed IF_ID / ID_EX / EX_MEM / MEM_WB stage registers.
- A chain of STAGES data registers, each with its own valid bit, under a valid/ready handshake.
- Supports backpressure stall, bubble collapsing (empty slots are filled while the output is stalled) and synchronous flush.
- Used between CPU pipeline stages wherever a stage needs to stall or squash the instructions it holds.

Parameters:
- WIDTH, 32: payload width in bits (1..256).
- STAGES, 1: number of register slots in the chain (1..7); also the minimum latency in cycles.
- RESET_VAL, 0: value loaded into every data slot on reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream is presenting in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WIDTH  upstream payload.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  slot STAGES-1 holds a valid entry.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  WIDTH  payload of slot STAGES-1.
- occupancy  output  3  count of valid slots (0..STAGES).
- stall_cnt  output  32  stall statistics counter (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clock edge):
  - All valid bits are cleared and every data slot is loaded with RESET_VAL.
  - Resulting outputs: out_valid=0, out_data=RESET_VAL, occupancy=0, stall_cnt=0.
  - Reset takes priority over flush and over any handshake in the same cycle.
- Transfer definitions:
  - Input transfer: in_valid && in_ready.
  - Output transfer: out_valid && out_ready.
- Slot advance rule (combinational):
  - adv[STAGES-1] = out_ready || !v[STAGES-1].
  - adv[i] = adv[i+1] || !v[i] for i < STAGES-1.
  - in_ready = adv[0] && !flush.
  - The ready chain is combinational; nothing is registered on it.
- On an edge with no rst and no flush:
  - Each slot i>0 with adv[i] takes slot i-1's data and valid.
  - Slot 0 with adv[0] takes in_data, with valid = in_valid.
  - A slot with adv=0 holds its data and valid.
  - An invalid slot whose predecessor is also invalid takes valid=0; its data is don't-care, but the implementation holds the old value.
- Latency: with out_ready held at 1, an entry accepted at edge N appears on out_valid/out_data after edge N+STAGES-1. For STAGES=1 it is visible the cycle after acceptance.
- Throughput: 1 entry/cycle when out_ready=1. Full capacity when stalled = STAGES entries.
- Bubble collapsing: while out_ready=0, new entries are still accepted until every slot is valid. Then in_ready=0.
- Ordering: strict FIFO order. No entry is duplicated or dropped except by flush or rst.
- Flush (flush=1, rst=0):
  - In the flush cycle, out_valid is gated to 0 and in_ready=0, so no handshake occurs.
  - At the edge, all valid bits are cleared; data slots hold their values.
  - In the next cycle, occupancy=0 and in_ready=1.
- Simultaneous input and output transfer when full: both transfers are allowed; occupancy is unchanged.
- occupancy is registered:
  - +1 on an input transfer without an output transfer.
  - -1 on an output transfer without an input transfer.
  - Forced to 0 by flush or rst.
  - Never exceeds STAGES and never underflows; a bench assertion checks it always equals the popcount of the valid bits.
- Parameter check: STAGES outside 1..7 must fail elaboration.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- With the macro defined, stall_cnt is a 32-bit register:
  - Increments on every cycle with out_valid && !out_ready && !flush.
  - Saturates at 0xFFFFFFFF.
  - Cleared only by rst; flush does not clear it.
- Without the macro, stall_cnt is tied to 32'h0 and no counter logic is built.

Test Plan:
- Streaming, STAGES=3, out_ready=1: drive 0x11, 0x22, 0x33 on consecutive cycles from edge 0 -> out_data shows 0x11, 0x22, 0x33 after edges 2, 3, 4 respectively; occupancy never exceeds 3.
- Fill under stall, STAGES=3, out_ready=0: push 0xA, 0xB, 0xC, 0xD -> 0xD is held at in_ready=0, occupancy=3. Then raise out_ready -> output order 0xA, 0xB, 0xC, 0xD with no gaps.
- Bubble collapse, STAGES=3: push 0x5, idle one cycle, push 0x6, then out_ready=0 -> both entries are packed into slots 2 and 1 and occupancy=2.
- Flush, STAGES=3: hold 3 valid entries, assert flush for 1 cycle -> out_valid=0 and in_ready=0 during the flush cycle; the next cycle has occupancy=0 and in_ready=1; old data never reappears on an output transfer.
- Reset mid-stream: rst=1 while 2 entries are held and flush=1 -> next cycle has out_valid=0, out_data=RESET_VAL, occupancy=0, stall_cnt=0.
- PIPE_STALL_CNT_EN defined: one valid entry at the output with out_ready=0 for 5 cycles -> stall_cnt=5; a following flush leaves stall_cnt=5. With the macro undefined, stall_cnt reads 0 throughout.
